dcache1_wb_queue: RTL and testbench
===================================

# dcache1_wb_queue

Victim write-back queue sitting directly downstream of the L1 data-cache tag ways. On each line replacement it captures the evicted line address and valid bit that the tag ways drive onto their shared write-back bus, and holds valid victims in a small FIFO. It drains them to the L2 request port over a valid/ready handshake and gives back-pressure to the fill path. It also provides a combinational match port so loads can detect a hit on a pending victim.

## Interface
- DEPTH, 4: number of queue entries; must be a power of 2, minimum 2.
- LADDR_WIDTH, 37: width of the write-back line address. This is paddr[43:8] plus the odd/even bank bit, as driven on wb_addr.
- clk  in  1  clock; all state updates on negedge clk.
- rst  in  1  synchronous, active-low reset; sampled on the negedge of clk.
- wb_en  in  1  replacement strobe, i.e. the OR of the ways' write_hit, one cycle per fill.
- wb_addr  in  LADDR_WIDTH  victim line address; meaningful only while wb_en=1.
- wb_valid  in  1  victim line was valid; an invalid victim is not enqueued.
- wbq_full  out  1  registered; while 1, the fill controller must not assert write_wen.
- l2_valid  out  1  the head entry is presented to L2.
- l2_addr  out  LADDR_WIDTH  head entry address; 0 when the queue is empty.
- l2_ready  in  1  L2 accepts the head entry this cycle.
- chk_addr  in  LADDR_WIDTH  load line address to check against pending victims.
- chk_hit  out  1  combinational; chk_addr equals a valid entry, including the head.
- wbq_empty  out  1  registered; no entries are pending.

## Operation
- Storage:
  - DEPTH entries of {addr, v}.
  - Write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping modulo DEPTH.
  - Count cnt of log2(DEPTH)+1 bits.
- Enqueue condition: enq = wb_en & wb_valid & ~dup & (~full | deq).
  - dup = wb_addr matches a valid entry. A duplicate is dropped silently: no entry is allocated and wp and cnt are unchanged.
  - wb_en with wb_valid=0: no action.
- Dequeue condition: deq = l2_valid & l2_ready.
  - On dequeue, the head v is cleared, rp increments, and cnt decrements.
- Simultaneous enq and deq:
  - cnt is unchanged; both pointers advance.
  - When full, enq is accepted in the deq cycle because the freed slot is reused.
- wb_en while full without deq: this is a protocol violation. The entry is dropped and the sticky debug flag ovf_err is set; ovf_err is cleared only by reset.
- l2_valid = ~empty. l2_addr and l2_valid stay stable until accepted; the head never changes while l2_valid=1 and l2_ready=0.
- chk_hit:
  - Compares against entries with v=1 only.
  - Does not see an entry being enqueued in the same cycle.
  - Does see the head in its dequeue cycle.
- Reset (rst=0): wp=rp=0, cnt=0, all v=0, ovf_err=0. Reset mid-drain discards all pending victims. Address storage is not cleared.
- Reset output values: wbq_full=0, wbq_empty=1, l2_valid=0, l2_addr=0, chk_hit=0.

## Timing
- Enqueue latency: a victim presented with wb_en at negedge N is visible on l2_valid/l2_addr after negedge N when the queue was empty. This is a 1-cycle latency.
- wbq_full and wbq_empty are registered, derived from the next value of cnt.
  - wbq_full asserts in the cycle after the enqueue that fills the last slot.
  - wbq_full deasserts in the cycle after the first dequeue from full.
- Throughput: one enqueue and one dequeue per cycle sustained.
- chk_hit: zero-cycle combinational path from chk_addr through a DEPTH-way compare.

## Structure
- Shared package constants: `dcache1_wbq_depth` and the line-address width (PADDR_WIDTH-7), placed in struct.sv alongside the dc1Tag fields.
- One sub-module, dcache1_wbq_cam: DEPTH address registers with valid bits, two compare ports (dup and chk), and write/clear enables.
- The top level holds the pointers, the counter, the full/empty registers and ovf_err.

## Test plan
- Reset then a single victim: rst=0 for 2 cycles, then wb_en=1, wb_valid=1, wb_addr=0x0_1234_5679.
  - Next cycle: l2_valid=1, l2_addr=0x012345679, wbq_empty=0.
  - l2_ready=1 for one cycle: l2_valid=0, wbq_empty=1.
- Fill to full: 4 distinct victims with l2_ready=0.
  - wbq_full=1 after the 4th.
  - A 5th wb_en with l2_ready=1 in the same cycle: 5th accepted, count stays 4, ovf_err=0.
- Overflow: full, l2_ready=0, wb_en=1 → entry dropped, ovf_err=1.
  - A drain then returns exactly the original 4 addresses in order.
- Duplicate and invalid victims:
  - Enqueue A, then A again: one L2 request only.
  - wb_valid=0 victim: nothing is enqueued.
- chk_hit:
  - With entry B pending, chk_addr=B gives chk_hit=1.
  - In B's dequeue cycle chk_hit is still 1; in the next cycle it is 0.
  - chk_addr equal to an address being enqueued in the same cycle gives chk_hit=0.
- Wrap and reset:
  - Run 10 enqueue/dequeue pairs with random l2_ready: FIFO order holds across pointer wrap.
  - rst=0 with 3 pending: l2_valid=0 and wbq_empty=1 the next cycle, and no stale entry reappears.

Source files
------------

// File: rtl/dcache1_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache1_wb_queue_pkg
// Description : Shared constants and types for the L1D victim write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache1_wb_queue_pkg;

    localparam int c_paddr_width       = 44;
    // Line address is paddr[43:8] plus the odd/even bank bit.
    localparam int c_laddr_width       = c_paddr_width - 7;
    localparam int c_dcache1_wbq_depth = 4;

    typedef struct packed {
        logic [c_laddr_width-1:0] addr;
        logic                     v;
    } wbq_entry_t;

    function automatic int wbq_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache1_wbq_cam.sv
`default_nettype none
// ============================================================================
// Module      : dcache1_wbq_cam
// Description : Victim address store with valid bits, one read port and two
//               fully-associative compare ports (duplicate and load check).
// Revision    : 1.0 - initial release
// ============================================================================
module dcache1_wbq_cam
    import dcache1_wb_queue_pkg::*;
#(
    parameter int DEPTH       = c_dcache1_wbq_depth,
    parameter int LADDR_WIDTH = c_laddr_width,
    parameter int PTR_WIDTH   = wbq_ptr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [PTR_WIDTH-1:0]   wr_idx,
    input  logic [LADDR_WIDTH-1:0] wr_addr,
    input  logic                   clr_en,
    input  logic [PTR_WIDTH-1:0]   clr_idx,
    input  logic [PTR_WIDTH-1:0]   rd_idx,
    output logic [LADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_v,
    input  logic [LADDR_WIDTH-1:0] dup_addr,
    output logic                   dup_hit,
    input  logic [LADDR_WIDTH-1:0] chk_addr,
    output logic                   chk_hit
);

    logic [LADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DEPTH-1:0]       r_v;
    logic [DEPTH-1:0]       w_dup_vec;
    logic [DEPTH-1:0]       w_chk_vec;

    // Address storage is deliberately left out of reset.
    always_ff @(negedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_idx == PTR_WIDTH'(i))) begin
                r_addr[i] <= wr_addr;
            end
        end
    end

    // A write to the slot being freed in the same cycle must leave it valid.
    always_ff @(negedge clk) begin
        if (!rst) begin
            r_v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_idx == PTR_WIDTH'(i))) begin
                    r_v[i] <= 1'b1;
                end else if (clr_en && (clr_idx == PTR_WIDTH'(i))) begin
                    r_v[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_dup_vec[gi] = r_v[gi] && (r_addr[gi] == dup_addr);
            assign w_chk_vec[gi] = r_v[gi] && (r_addr[gi] == chk_addr);
        end
    endgenerate

    assign dup_hit = |w_dup_vec;
    assign chk_hit = |w_chk_vec;
    assign rd_v    = r_v[rd_idx];
    assign rd_addr = r_addr[rd_idx];

endmodule
`default_nettype wire

// File: rtl/dcache1_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : dcache1_wb_queue
// Description : L1D victim write-back FIFO draining to L2 over valid/ready,
//               with duplicate filtering, load-hit check and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache1_wb_queue
    import dcache1_wb_queue_pkg::*;
#(
    parameter int DEPTH       = c_dcache1_wbq_depth,
    parameter int LADDR_WIDTH = c_laddr_width
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_en,
    input  logic [LADDR_WIDTH-1:0] wb_addr,
    input  logic                   wb_valid,
    output logic                   wbq_full,
    output logic                   l2_valid,
    output logic [LADDR_WIDTH-1:0] l2_addr,
    input  logic                   l2_ready,
    input  logic [LADDR_WIDTH-1:0] chk_addr,
    output logic                   chk_hit,
    output logic                   wbq_empty,
    output logic                   ovf_err
);

    localparam int                   c_ptr_width = wbq_ptr_width(DEPTH);
    localparam logic [c_ptr_width-1:0] c_ptr_one = c_ptr_width'(1);
    localparam logic [c_ptr_width:0]   c_cnt_one  = (c_ptr_width + 1)'(1);
    localparam logic [c_ptr_width:0]   c_cnt_full = (c_ptr_width + 1)'(DEPTH);

    logic [c_ptr_width-1:0] r_wp;
    logic [c_ptr_width-1:0] r_rp;
    logic [c_ptr_width:0]   r_cnt;
    logic [c_ptr_width:0]   w_cnt_next;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_ovf_err;

    logic                   w_enq;
    logic                   w_deq;
    logic                   w_dup;
    logic                   w_ovf;
    logic                   w_head_v;
    logic [LADDR_WIDTH-1:0] w_head_addr;

    dcache1_wbq_cam #(
        .DEPTH       (DEPTH),
        .LADDR_WIDTH (LADDR_WIDTH),
        .PTR_WIDTH   (c_ptr_width)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_enq),
        .wr_idx   (r_wp),
        .wr_addr  (wb_addr),
        .clr_en   (w_deq),
        .clr_idx  (r_rp),
        .rd_idx   (r_rp),
        .rd_addr  (w_head_addr),
        .rd_v     (w_head_v),
        .dup_addr (wb_addr),
        .dup_hit  (w_dup),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit)
    );

    assign l2_valid = ~r_empty;
    assign w_deq    = l2_valid & l2_ready;
    // A full queue still accepts a victim when the head leaves this cycle.
    assign w_enq    = wb_en & wb_valid & ~w_dup & (~r_full | w_deq);
    assign w_ovf    = wb_en & r_full & ~w_deq;

    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_enq, w_deq})
            2'b10:   w_cnt_next = r_cnt + c_cnt_one;
            2'b01:   w_cnt_next = r_cnt - c_cnt_one;
            default: w_cnt_next = r_cnt;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_deq) begin
                r_rp <= r_rp + c_ptr_one;
            end
            r_cnt   <= w_cnt_next;
            r_full  <= (w_cnt_next == c_cnt_full);
            r_empty <= (w_cnt_next == '0);
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign l2_addr   = w_head_v ? w_head_addr : '0;
    assign wbq_full  = r_full;
    assign wbq_empty = r_empty;
    assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_dcache1_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache1_wb_queue
// Description : Self-checking bench for the victim write-back queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache1_wb_queue;
    import dcache1_wb_queue_pkg::*;

    localparam int AW    = c_laddr_width;
    localparam int DEPTH = 4;
    typedef logic [AW-1:0] addr_t;

    localparam addr_t A = 37'h0_1234_5679;
    localparam addr_t B = 37'h00_0000_1000;
    localparam addr_t C = 37'h00_0000_2000;
    localparam addr_t D = 37'h00_0000_3000;
    localparam addr_t E = 37'h00_0000_4000;
    localparam addr_t F = 37'h00_0000_5000;

    typedef struct {
        logic  en;
        logic  val;
        addr_t addr;
        logic  rdy;
        addr_t chk;
        logic  hit;
        logic  lv;
        addr_t la;
        logic  full;
        logic  empty;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  wb_en = 1'b0;
    logic  wb_valid = 1'b0;
    logic  l2_ready = 1'b0;
    addr_t wb_addr = '0;
    addr_t chk_addr = '0;
    logic  wbq_full;
    logic  l2_valid;
    logic  chk_hit;
    logic  wbq_empty;
    logic  ovf_err;
    addr_t l2_addr;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    n_deq    = 0;
    addr_t mq[$];
    logic  m_ovf    = 1'b0;
    logic  last_hit = 1'b0;
    vec_t  tbl[11];

    always #5 clk = ~clk;

    dcache1_wb_queue #(
        .DEPTH       (DEPTH),
        .LADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_valid  (wb_valid),
        .wbq_full  (wbq_full),
        .l2_valid  (l2_valid),
        .l2_addr   (l2_addr),
        .l2_ready  (l2_ready),
        .chk_addr  (chk_addr),
        .chk_hit   (chk_hit),
        .wbq_empty (wbq_empty),
        .ovf_err   (ovf_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle between posedges; the DUT updates on the negedge.
    task automatic step(input logic en, input logic val, input addr_t addr,
                        input logic rdy, input addr_t chk);
        logic  hit_m, dup_m, full_m, deq_m;
        addr_t head_m;
        @(posedge clk);
        wb_en    = en;
        wb_valid = val;
        wb_addr  = addr;
        l2_ready = rdy;
        chk_addr = chk;
        #1;
        hit_m = 1'b0;
        dup_m = 1'b0;
        foreach (mq[i]) begin
            if (mq[i] == chk)  hit_m = 1'b1;
            if (mq[i] == addr) dup_m = 1'b1;
        end
        last_hit = chk_hit;
        check("chk_hit", chk_hit, hit_m);
        check("l2_valid_pre", l2_valid, mq.size() != 0);
        full_m = (mq.size() == DEPTH);
        deq_m  = (mq.size() != 0) && rdy;
        if (rst && deq_m) check("l2_addr_deq", l2_addr, mq[0]);
        @(negedge clk);
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (deq_m) begin
                void'(mq.pop_front());
                n_deq++;
            end
            if (en && full_m && !deq_m) m_ovf = 1'b1;
            if (en && val && !dup_m && (!full_m || deq_m)) mq.push_back(addr);
        end
        #1;
        head_m = '0;
        if (mq.size() != 0) head_m = mq[0];
        check("l2_valid", l2_valid, mq.size() != 0);
        check("l2_addr", l2_addr, head_m);
        check("wbq_full", wbq_full, mq.size() == DEPTH);
        check("wbq_empty", wbq_empty, mq.size() == 0);
        check("ovf_err", ovf_err, m_ovf);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    start_deq;
        int    enq_n;
        int    cyc;
        logic  en_now;

        //            en val addr rdy chk  hit lv la full empty
        tbl[0]  = '{1'b1, 1'b1, A,  1'b0, A, 1'b0, 1'b1, A,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, '0, 1'b1, A, 1'b1, 1'b0, '0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, '0, 1'b0, A, 1'b0, 1'b0, '0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, B,  1'b0, B, 1'b0, 1'b1, B,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, B,  1'b0, B, 1'b1, 1'b1, B,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, C,  1'b0, C, 1'b0, 1'b1, B,  1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, C,  1'b0, C, 1'b0, 1'b1, B,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, D,  1'b0, C, 1'b1, 1'b1, B,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, E,  1'b0, B, 1'b1, 1'b1, B,  1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, F,  1'b1, B, 1'b1, 1'b1, C,  1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, '0, 1'b0, B, 1'b0, 1'b1, C,  1'b1, 1'b0};

        rst = 1'b0;
        @(negedge clk);
        #1;
        step(1'b0, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0);
        check("rst_l2_valid", l2_valid, 1'b0);
        check("rst_l2_addr", l2_addr, '0);
        check("rst_full", wbq_full, 1'b0);
        check("rst_empty", wbq_empty, 1'b1);
        check("rst_chk_hit", last_hit, 1'b0);
        check("rst_ovf", ovf_err, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].val, tbl[i].addr, tbl[i].rdy, tbl[i].chk);
            check($sformatf("tbl%0d_hit", i), last_hit, tbl[i].hit);
            check($sformatf("tbl%0d_lv", i), l2_valid, tbl[i].lv);
            check($sformatf("tbl%0d_la", i), l2_addr, tbl[i].la);
            check($sformatf("tbl%0d_full", i), wbq_full, tbl[i].full);
            check($sformatf("tbl%0d_empty", i), wbq_empty, tbl[i].empty);
        end
        check("dup_single_request", n_deq, 2);
        check("no_ovf_on_full_deq", ovf_err, 1'b0);

        // Overflow: full, no dequeue, victim arrives.
        step(1'b1, 1'b1, 37'h6000, 1'b0, 37'h6000);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_still_full", wbq_full, 1'b1);
        check("ovf_head_kept", l2_addr, C);

        start_deq = n_deq;
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("full_deassert", wbq_full, 1'b0);
        check("drain_head_d", l2_addr, D);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        check("drain_head_f", l2_addr, F);
        step(1'b0, 1'b0, '0, 1'b1, 37'h6000);
        check("drain_empty", wbq_empty, 1'b1);
        check("drain_count", n_deq - start_deq, 4);
        check("dropped_not_pending", last_hit, 1'b0);

        // Pointer wrap with random back-pressure.
        start_deq = n_deq;
        enq_n = 0;
        cyc = 0;
        while ((enq_n < 10 || mq.size() != 0) && cyc < 200) begin
            en_now = (enq_n < 10) && (mq.size() < DEPTH);
            step(en_now, en_now, addr_t'(37'h7000 + 37'(enq_n)),
                 1'($urandom_range(0, 1)), 37'h7000);
            if (en_now) enq_n++;
            cyc++;
        end
        check("wrap_budget", cyc < 200, 1'b1);
        check("wrap_drained", n_deq - start_deq, 10);

        // Reset with three victims pending.
        step(1'b1, 1'b1, 37'h9000, 1'b0, '0);
        step(1'b1, 1'b1, 37'h9001, 1'b0, '0);
        step(1'b1, 1'b1, 37'h9002, 1'b0, 37'h9000);
        check("pre_rst_hit", last_hit, 1'b1);
        rst = 1'b0;
        step(1'b0, 1'b0, '0, 1'b1, 37'h9000);
        check("midrst_l2_valid", l2_valid, 1'b0);
        check("midrst_empty", wbq_empty, 1'b1);
        check("midrst_ovf", ovf_err, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 37'h9000 + 37'(i));
            check($sformatf("stale%0d_valid", i), l2_valid, 1'b0);
            check($sformatf("stale%0d_hit", i), last_hit, 1'b0);
        end
        step(1'b1, 1'b1, 37'hA000, 1'b0, '0);
        check("post_rst_head", l2_addr, 37'hA000);
        step(1'b0, 1'b0, '0, 1'b1, 37'hA000);
        check("post_rst_deq_hit", last_hit, 1'b1);
        check("post_rst_empty", wbq_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
